axil_bram_mux: RTL and testbench
================================

# axil_bram_mux

Multi-master AXI4-Lite slave that shares one single-port BRAM among `NUM_M` masters, with full read and write support. It succeeds the read-only instruction-fetch bus: the CPU's instruction port and data port (and later a debug/loader port) each attach as one master. Grants are round-robin, one transaction in flight at a time. Out-of-range addresses are rejected with SLVERR instead of aliasing.

## Interface
Parameters:
- `NUM_M`, 2: number of AXI4-Lite masters.
- `DATA_W`, 32: data width; must be a power of two and at least 8.
- `ADDR_W`, 32: byte address width.
- `BRAM_DEPTH`, 1024: BRAM words.
- `BRAM_ADDR_W`, `$clog2(BRAM_DEPTH)`: BRAM word-address width.

Ports (`S_*` are packed per master; master i occupies slice i):
- `ACLK` in 1: clock. One clock domain; all logic on its rising edge.
- `ARESETn` in 1: reset, asynchronous assert, active-low.
- `S_AR_VALID` in NUM_M; `S_AR_READY` out NUM_M; `S_AR_ADDR` in NUM_M*ADDR_W.
- `S_R_VALID` out NUM_M; `S_R_READY` in NUM_M; `S_R_DATA` out NUM_M*DATA_W; `S_R_RESP` out NUM_M*2.
- `S_AW_VALID` in NUM_M; `S_AW_READY` out NUM_M; `S_AW_ADDR` in NUM_M*ADDR_W.
- `S_W_VALID` in NUM_M; `S_W_READY` out NUM_M; `S_W_DATA` in NUM_M*DATA_W; `S_W_STRB` in NUM_M*DATA_W/8.
- `S_B_VALID` out NUM_M; `S_B_READY` in NUM_M; `S_B_RESP` out NUM_M*2.
- `SLAVE_ADDR` out BRAM_ADDR_W: BRAM word address.
- `SLAVE_WE` out DATA_W/8: byte write enables.
- `SLAVE_DIN` out DATA_W: BRAM write data.
- `SLAVE_DOUT` in DATA_W: BRAM read data. Valid one cycle after `SLAVE_ADDR`, and held while the address is held.

## Operation
- Master i requests when `AR_VALID[i] | (AW_VALID[i] & W_VALID[i])`. AW without W, or W without AW, is not a request.
- Arbitration happens only in IDLE.
  - Round-robin pointer `rr`, reset 0. Search order is rr, rr+1, … (mod NUM_M).
  - After each grant, `rr` becomes the granted index + 1.
- Op select for the granted master:
  - Only one op pending: take it.
  - Both pending: take the op opposite to global `last_op` (reset = WRITE, so read goes first).
  - `last_op` updates on each grant.
- Address decode: `OFF = $clog2(DATA_W/8)`; word = `ADDR[BRAM_ADDR_W+OFF-1:OFF]`.
  - Address is out-of-range if any of `ADDR[ADDR_W-1:BRAM_ADDR_W+OFF]` is set.
  - Low `OFF` bits are ignored.
- Reads:
  - In range: return BRAM data with RESP=2'b00 (OKAY).
  - Out of range: R_DATA=0, RESP=2'b10 (SLVERR).
- Writes:
  - In range: `SLAVE_WE = W_STRB` for one cycle, RESP OKAY.
  - Out of range: `SLAVE_WE` stays 0, RESP SLVERR.
- FSM states: IDLE → RD_MEM → RD_CAP → RD_RESP → IDLE, and IDLE → WR_MEM → WR_RESP → IDLE.
  - RD_RESP leaves on `R_VALID & R_READY` of the granted master.
  - WR_RESP leaves on `B_VALID & B_READY` of the granted master.
- Non-granted masters see all READY and VALID outputs at 0.

## Timing
- Cycle 0 (IDLE, request present): READY is asserted combinationally to the granted master only.
  - Read: `AR_READY`.
  - Write: `AW_READY` and `W_READY` together.
  - Address, data and strobes are registered at the end of cycle 0.
- Read path:
  - Cycle 1 (RD_MEM): `SLAVE_ADDR` driven.
  - Cycle 2 (RD_CAP): `SLAVE_DOUT` captured.
  - Cycle 3: `R_VALID` high.
  - `R_DATA` and `R_RESP` stay stable until R_READY is seen, which may be the same cycle.
- Write path:
  - Cycle 1 (WR_MEM): `SLAVE_WE`, `SLAVE_ADDR` and `SLAVE_DIN` driven for exactly one cycle.
  - Cycle 2: `B_VALID` high until B_READY.
- After the response handshake the FSM returns to IDLE. The next grant comes earliest one cycle later.
  - Best-case throughput: 1 read per 4 cycles, 1 write per 3 cycles.
- Reset values: every READY/VALID output 0, all data and resp outputs 0, `SLAVE_*` outputs 0, state IDLE, `rr`=0, `last_op`=WRITE.
- Reset asserted mid-transaction:
  - Abandon the transaction; no response is issued.
  - `SLAVE_WE` clears asynchronously, so a write in WR_MEM is not guaranteed to complete.
- `SLAVE_WE` is 0 in every state except WR_MEM.

## Structure
- Package `axil_pkg`:
  - `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10.
  - FSM state enum.
  - Op enum (READ/WRITE).
- Sub-module `rr_arbiter` (parameter `NUM_M`):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, granted index, grant-valid. Purely combinational.
  - The pointer register stays in `axil_bram_mux`.

## Test plan
- Single read, NUM_M=2: master0 reads 0x10 with BRAM word 4 = 0xDEADBEEF → R_VALID 3 cycles after the AR handshake, R_DATA=0xDEADBEEF, RESP=0.
- Write strobe: master1 writes 0x11223344 to 0x20 with STRB=4'b0101 → `SLAVE_WE`=0101 for exactly one cycle, SLAVE_ADDR=8. A following read returns old bytes merged with 0x..22..44.
- Contention: both masters hold AR_VALID continuously.
  - Grants alternate 0,1,0,1.
  - No grant while R_READY is held low for 5 cycles.
- Mixed ops on one master: AR and AW+W asserted together from reset → read served first, then the write.
- Out of range: read at 0x1000 (DEPTH=1024) → R_DATA=0, RESP=2'b10. A write to 0x1000 → SLAVE_WE stays 0 and B_RESP=2'b10.
- Reset in WR_MEM and in RD_RESP → outputs return to their reset values immediately, and the next request is served normally starting from master0.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared types and constants for the AXI4-Lite BRAM mux.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Transaction FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MEM  = 3'd1,
        ST_RD_CAP  = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_WR_MEM  = 3'd4,
        ST_WR_RESP = 3'd5
    } state_t;

    // Operation kind served for a grant
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting at the pointer and wrapping modulo NUM_M.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NUM_M-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    // First requester at or after the pointer wins
    always_comb begin
        int w_j;
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_j         = 0;
        for (int k = 0; k < NUM_M; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_M;
            if (!o_gnt_valid && i_req[w_j]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = IDX_W'(w_j);
                o_gnt[w_j]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_bram_mux.sv
`default_nettype none
// ============================================================================
// Module      : axil_bram_mux
// Description : Multi-master AXI4-Lite slave sharing one single-port BRAM.
//               Round-robin grants, one transaction in flight, SLVERR for
//               addresses beyond the BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_bram_mux
    import axil_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BRAM_DEPTH  = 1024,
    parameter int BRAM_ADDR_W = $clog2(BRAM_DEPTH)
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_M-1:0]          S_AR_VALID,
    output logic [NUM_M-1:0]          S_AR_READY,
    input  logic [NUM_M*ADDR_W-1:0]   S_AR_ADDR,
    output logic [NUM_M-1:0]          S_R_VALID,
    input  logic [NUM_M-1:0]          S_R_READY,
    output logic [NUM_M*DATA_W-1:0]   S_R_DATA,
    output logic [NUM_M*2-1:0]        S_R_RESP,
    input  logic [NUM_M-1:0]          S_AW_VALID,
    output logic [NUM_M-1:0]          S_AW_READY,
    input  logic [NUM_M*ADDR_W-1:0]   S_AW_ADDR,
    input  logic [NUM_M-1:0]          S_W_VALID,
    output logic [NUM_M-1:0]          S_W_READY,
    input  logic [NUM_M*DATA_W-1:0]   S_W_DATA,
    input  logic [NUM_M*DATA_W/8-1:0] S_W_STRB,
    output logic [NUM_M-1:0]          S_B_VALID,
    input  logic [NUM_M-1:0]          S_B_READY,
    output logic [NUM_M*2-1:0]        S_B_RESP,
    output logic [BRAM_ADDR_W-1:0]    SLAVE_ADDR,
    output logic [DATA_W/8-1:0]       SLAVE_WE,
    output logic [DATA_W-1:0]         SLAVE_DIN,
    input  logic [DATA_W-1:0]         SLAVE_DOUT
);

    localparam int c_idx_w  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int c_strb_w = DATA_W / 8;
    localparam int c_off    = $clog2(c_strb_w);
    localparam int c_hi     = BRAM_ADDR_W + c_off;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_M - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    op_t                    r_last_op;
    op_t                    w_op;
    logic [c_idx_w-1:0]     r_rr;
    logic [c_idx_w-1:0]     w_arb_idx;
    logic [c_idx_w-1:0]     w_rr_nxt;
    logic [NUM_M-1:0]       r_gnt_oh;
    logic [NUM_M-1:0]       w_arb_gnt;
    logic [NUM_M-1:0]       w_req;
    logic                   w_arb_valid;
    logic                   w_start;
    logic                   w_rd_pend;
    logic                   w_wr_pend;
    logic                   w_oor;
    logic                   w_r_hs;
    logic                   w_b_hs;
    logic [ADDR_W-1:0]      w_sel_ar_addr;
    logic [ADDR_W-1:0]      w_sel_aw_addr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [c_strb_w-1:0]    w_sel_wstrb;
    logic [BRAM_ADDR_W-1:0] w_word;
    logic [BRAM_ADDR_W-1:0] r_addr;
    logic                   r_oor;
    logic [DATA_W-1:0]      r_wdata;
    logic [c_strb_w-1:0]    r_wstrb;
    logic [DATA_W-1:0]      r_rdata;
    logic [1:0]             r_resp;

    // A master requests with a read address or a complete write (AW and W)
    generate
        for (genvar i = 0; i < NUM_M; i++) begin : g_req
            assign w_req[i] = S_AR_VALID[i] | (S_AW_VALID[i] & S_W_VALID[i]);
        end
    endgenerate

    rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (c_idx_w)
    ) u_arb (
        .i_req       (w_req),
        .i_ptr       (r_rr),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    assign w_start   = (r_state == ST_IDLE) & w_arb_valid;
    assign w_rd_pend = |(S_AR_VALID & w_arb_gnt);
    assign w_wr_pend = |(S_AW_VALID & S_W_VALID & w_arb_gnt);
    assign w_rr_nxt  = (w_arb_idx == c_last_idx) ? '0 : w_arb_idx + 1'b1;
    assign w_r_hs    = |(S_R_READY & r_gnt_oh);
    assign w_b_hs    = |(S_B_READY & r_gnt_oh);

    // Pick the op for the granted master; alternate when both are pending
    always_comb begin
        w_op = OP_READ;
        if (w_rd_pend && w_wr_pend) begin
            w_op = (r_last_op == OP_WRITE) ? OP_READ : OP_WRITE;
        end else if (w_wr_pend) begin
            w_op = OP_WRITE;
        end
    end

    // One-hot mux of the granted master's address, data and strobes
    always_comb begin
        w_sel_ar_addr = '0;
        w_sel_aw_addr = '0;
        w_sel_wdata   = '0;
        w_sel_wstrb   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_arb_gnt[i]) begin
                w_sel_ar_addr = S_AR_ADDR[i*ADDR_W +: ADDR_W];
                w_sel_aw_addr = S_AW_ADDR[i*ADDR_W +: ADDR_W];
                w_sel_wdata   = S_W_DATA[i*DATA_W +: DATA_W];
                w_sel_wstrb   = S_W_STRB[i*c_strb_w +: c_strb_w];
            end
        end
    end

    assign w_sel_addr = (w_op == OP_READ) ? w_sel_ar_addr : w_sel_aw_addr;
    assign w_word     = w_sel_addr[c_hi-1:c_off];

    // Any address bit above the BRAM span marks the access out of range
    generate
        if (ADDR_W > c_hi) begin : g_oor_chk
            assign w_oor = |w_sel_addr[ADDR_W-1:c_hi];
        end else begin : g_oor_none
            assign w_oor = 1'b0;
        end
    endgenerate

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = (w_op == OP_READ) ? ST_RD_MEM : ST_WR_MEM;
                end
            end
            ST_RD_MEM:  w_state_nxt = ST_RD_CAP;
            ST_RD_CAP:  w_state_nxt = ST_RD_RESP;
            ST_RD_RESP: if (w_r_hs) w_state_nxt = ST_IDLE;
            ST_WR_MEM:  w_state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping and transaction datapath
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rr      <= '0;
            r_last_op <= OP_WRITE;
            r_gnt_oh  <= '0;
            r_addr    <= '0;
            r_oor     <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
        end else begin
            if (w_start) begin
                r_rr      <= w_rr_nxt;
                r_last_op <= w_op;
                r_gnt_oh  <= w_arb_gnt;
                r_addr    <= w_word;
                r_oor     <= w_oor;
                r_resp    <= w_oor ? RESP_SLVERR : RESP_OKAY;
                if (w_op == OP_WRITE) begin
                    r_wdata <= w_sel_wdata;
                    r_wstrb <= w_sel_wstrb;
                end
            end
            if (r_state == ST_RD_CAP) begin
                r_rdata <= r_oor ? '0 : SLAVE_DOUT;
            end
        end
    end

    // BRAM side: write enables only in WR_MEM, so reset kills them at once
    assign SLAVE_ADDR = r_addr;
    assign SLAVE_DIN  = r_wdata;
    assign SLAVE_WE   = ((r_state == ST_WR_MEM) && !r_oor) ? r_wstrb : '0;

    // Per-master handshake outputs; only the granted master sees activity
    generate
        for (genvar i = 0; i < NUM_M; i++) begin : g_port
            assign S_AR_READY[i] = w_start & w_arb_gnt[i] & (w_op == OP_READ);
            assign S_AW_READY[i] = w_start & w_arb_gnt[i] & (w_op == OP_WRITE);
            assign S_W_READY[i]  = w_start & w_arb_gnt[i] & (w_op == OP_WRITE);
            assign S_R_VALID[i]  = (r_state == ST_RD_RESP) & r_gnt_oh[i];
            assign S_B_VALID[i]  = (r_state == ST_WR_RESP) & r_gnt_oh[i];
            assign S_R_DATA[i*DATA_W +: DATA_W] = r_rdata;
            assign S_R_RESP[i*2 +: 2]           = r_resp;
            assign S_B_RESP[i*2 +: 2]           = r_resp;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_bram_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axil_bram_mux
// Description : Self-checking bench for axil_bram_mux (two masters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_bram_mux;

    localparam int NM    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int BAW   = 10;
    localparam int SW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]    ar_valid, ar_ready, r_valid, r_ready;
    logic [NM-1:0]    aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [NM*AW-1:0] ar_addr, aw_addr;
    logic [NM*DW-1:0] r_data, w_data;
    logic [NM*2-1:0]  r_resp, b_resp;
    logic [NM*SW-1:0] w_strb;
    logic [BAW-1:0]   slave_addr;
    logic [SW-1:0]    slave_we;
    logic [DW-1:0]    slave_din, slave_dout;

    axil_bram_mux #(
        .NUM_M(NM), .DATA_W(DW), .ADDR_W(AW), .BRAM_DEPTH(DEPTH), .BRAM_ADDR_W(BAW)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .S_AR_VALID(ar_valid), .S_AR_READY(ar_ready), .S_AR_ADDR(ar_addr),
        .S_R_VALID(r_valid), .S_R_READY(r_ready), .S_R_DATA(r_data), .S_R_RESP(r_resp),
        .S_AW_VALID(aw_valid), .S_AW_READY(aw_ready), .S_AW_ADDR(aw_addr),
        .S_W_VALID(w_valid), .S_W_READY(w_ready), .S_W_DATA(w_data), .S_W_STRB(w_strb),
        .S_B_VALID(b_valid), .S_B_READY(b_ready), .S_B_RESP(b_resp),
        .SLAVE_ADDR(slave_addr), .SLAVE_WE(slave_we), .SLAVE_DIN(slave_din),
        .SLAVE_DOUT(slave_dout)
    );

    // Single-port BRAM attached to the slave side
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < SW; b++) begin
            if (slave_we[b]) bram[slave_addr][8*b +: 8] <= slave_din[8*b +: 8];
        end
        slave_dout <= bram[slave_addr];
    end

    // Reference memory as the masters expect to see it
    logic [DW-1:0] ref_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_wr;
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_we;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit is_oor(input logic [31:0] addr);
        return addr >= 32'(DEPTH * SW);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr / SW);
    endfunction

    task automatic ref_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] rsp);
        if (is_oor(addr)) begin d = '0; rsp = 2'b10; end
        else begin d = ref_mem[word_of(addr)]; rsp = 2'b00; end
    endtask

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        if (!is_oor(addr)) ref_mem[word_of(addr)] = merge(ref_mem[word_of(addr)], d, s);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ar_ready"}, 64'(ar_ready), 0);
        chk({tag, "_aw_w_ready"}, 64'({aw_ready, w_ready}), 0);
        chk({tag, "_r_b_valid"}, 64'({r_valid, b_valid}), 0);
        chk({tag, "_r_data"}, 64'(r_data), 0);
        chk({tag, "_resps"}, 64'({r_resp, b_resp}), 0);
        chk({tag, "_slave_addr"}, 64'(slave_addr), 0);
        chk({tag, "_slave_we"}, 64'(slave_we), 0);
        chk({tag, "_slave_din"}, 64'(slave_din), 0);
    endtask

    // Called one cycle after the AR handshake; checks latency and response
    task automatic finish_read(input int m, input logic [31:0] ed, input logic [1:0] er,
                               input int hold);
        int n;
        n = 1;
        while (!r_valid[m] && n < 20) begin tick(); n++; end
        chk("rd_latency", 64'(n), 3);
        if (!r_valid[m]) return;
        for (int h = 0; h < hold; h++) begin
            chk("rd_hold_valid", 64'(r_valid[m]), 1);
            chk("rd_hold_data", 64'(r_data[m*DW +: DW]), 64'(ed));
            tick();
        end
        chk("rd_data", 64'(r_data[m*DW +: DW]), 64'(ed));
        chk("rd_resp", 64'(r_resp[m*2 +: 2]), 64'(er));
        r_ready[m] = 1'b1;
        tick();
        r_ready[m] = 1'b0;
        #1;
        chk("rd_valid_drop", 64'(r_valid[m]), 0);
    endtask

    task automatic do_read(input int m, input logic [31:0] addr, input logic [31:0] ed,
                           input logic [1:0] er, input int hold);
        int n;
        ar_valid[m] = 1'b1;
        ar_addr[m*AW +: AW] = addr;
        #1;
        n = 0;
        while (!ar_ready[m] && n < 20) begin tick(); n++; end
        if (!ar_ready[m]) begin
            chk("rd_ar_timeout", 0, 1);
            ar_valid[m] = 1'b0;
            return;
        end
        chk("rd_no_aw_ready", 64'(aw_ready | w_ready), 0);
        tick();
        ar_valid[m] = 1'b0;
        finish_read(m, ed, er, hold);
    endtask

    task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] exp_we,
                            input logic [1:0] er, input int hold);
        int n;
        aw_valid[m] = 1'b1; w_valid[m] = 1'b1;
        aw_addr[m*AW +: AW] = addr;
        w_data[m*DW +: DW] = d;
        w_strb[m*SW +: SW] = s;
        #1;
        n = 0;
        while (!aw_ready[m] && n < 20) begin tick(); n++; end
        if (!aw_ready[m]) begin
            chk("wr_aw_timeout", 0, 1);
            aw_valid[m] = 1'b0; w_valid[m] = 1'b0;
            return;
        end
        chk("wr_w_ready", 64'(w_ready[m]), 1);
        chk("wr_no_ar_ready", 64'(ar_ready), 0);
        tick();
        aw_valid[m] = 1'b0; w_valid[m] = 1'b0;
        chk("wr_slave_we", 64'(slave_we), 64'(exp_we));
        if (exp_we != 0) begin
            chk("wr_slave_addr", 64'(slave_addr), 64'(word_of(addr)));
            chk("wr_slave_din", 64'(slave_din), 64'(d));
        end
        chk("wr_b_early", 64'(b_valid), 0);
        tick();
        chk("wr_we_one_cycle", 64'(slave_we), 0);
        chk("wr_b_valid", 64'(b_valid[m]), 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("wr_b_hold", 64'(b_valid[m]), 1);
        end
        chk("wr_b_resp", 64'(b_resp[m*2 +: 2]), 64'(er));
        b_ready[m] = 1'b1;
        tick();
        b_ready[m] = 1'b0;
        #1;
        chk("wr_b_drop", 64'(b_valid[m]), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // After a reset both masters request; master0 must be served first
    task automatic both_reads_after_reset(input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] d0, d1;
        logic [1:0]  e0, e1;
        ref_read(a0, d0, e0);
        ref_read(a1, d1, e1);
        ar_addr[0 +: AW] = a0;
        ar_addr[AW +: AW] = a1;
        ar_valid = 2'b11;
        #1;
        chk("rst_first_grant", 64'(ar_ready), 2'b01);
        tick();
        ar_valid[0] = 1'b0;
        finish_read(0, d0, e0, 0);
        chk("rst_second_grant", 64'(ar_ready), 2'b10);
        tick();
        ar_valid[1] = 1'b0;
        finish_read(1, d1, e1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, a, d, ed;
        logic [3:0]  s;
        logic [1:0]  er;
        int          m, n;

        ar_valid = '0; aw_valid = '0; w_valid = '0; r_ready = '0; b_ready = '0;
        ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;

        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            bram[i] = v;
            ref_mem[i] = v;
        end
        bram[4] = 32'hDEADBEEF;    ref_mem[4] = 32'hDEADBEEF;
        bram[8] = 32'hAABBCCDD;    ref_mem[8] = 32'hAABBCCDD;
        bram[1023] = 32'h12345678; ref_mem[1023] = 32'h12345678;

        //              wr m  addr          wdata         strb   hold exp_data      resp   we
        vecs[0] = '{1'b0, 0, 32'h0000_0010, 32'h0,        4'h0,  0, 32'hDEADBEEF, 2'b00, 4'h0};
        vecs[1] = '{1'b1, 1, 32'h0000_0020, 32'h11223344, 4'h5,  0, 32'h0,        2'b00, 4'h5};
        vecs[2] = '{1'b0, 0, 32'h0000_0020, 32'h0,        4'h0,  2, 32'hAA22CC44, 2'b00, 4'h0};
        vecs[3] = '{1'b0, 1, 32'h0000_1000, 32'h0,        4'h0,  0, 32'h0,        2'b10, 4'h0};
        vecs[4] = '{1'b1, 0, 32'h0000_1000, 32'hFFFFFFFF, 4'hF,  1, 32'h0,        2'b10, 4'h0};
        vecs[5] = '{1'b0, 1, 32'h0000_0013, 32'h0,        4'h0,  0, 32'hDEADBEEF, 2'b00, 4'h0};
        vecs[6] = '{1'b0, 0, 32'h0000_0FFC, 32'h0,        4'h0,  0, 32'h12345678, 2'b00, 4'h0};
        vecs[7] = '{1'b1, 0, 32'h0000_0FFC, 32'hCAFEF00D, 4'hF,  0, 32'h0,        2'b00, 4'hF};
        vecs[8] = '{1'b0, 1, 32'h0000_0FFE, 32'h0,        4'h0,  1, 32'hCAFEF00D, 2'b00, 4'h0};

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                         vecs[i].exp_we, vecs[i].exp_resp, vecs[i].hold);
                ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            end else begin
                do_read(vecs[i].m, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp,
                        vecs[i].hold);
            end
            tick();
        end

        // Contention: both masters hold AR_VALID; grants alternate from master0
        pulse_reset();
        ar_addr[0 +: AW] = 32'h10;
        ar_addr[AW +: AW] = 32'h20;
        ar_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            m = g % 2;
            n = 0;
            while (ar_ready == 0 && n < 20) begin tick(); n++; end
            chk("cont_grant", 64'(ar_ready), 64'(2'b01 << m));
            tick();
            n = 1;
            while (!r_valid[m] && n < 20) begin tick(); n++; end
            chk("cont_latency", 64'(n), 3);
            for (int h = 0; h < 5; h++) begin
                chk("cont_no_grant", 64'(ar_ready | aw_ready), 0);
                chk("cont_valid_held", 64'(r_valid[m]), 1);
                tick();
            end
            ref_read(m == 0 ? 32'h10 : 32'h20, ed, er);
            chk("cont_data", 64'(r_data[m*DW +: DW]), 64'(ed));
            r_ready[m] = 1'b1;
            tick();
            r_ready[m] = 1'b0;
            #1;
        end
        ar_valid = 2'b00;
        tick();

        // Mixed ops on master0 straight after reset: read first, then write
        pulse_reset();
        ar_addr[0 +: AW] = 32'h40;
        aw_addr[0 +: AW] = 32'h40;
        w_data[0 +: DW] = 32'h5A5A5A5A;
        w_strb[0 +: SW] = 4'hF;
        ar_valid[0] = 1'b1; aw_valid[0] = 1'b1; w_valid[0] = 1'b1;
        #1;
        chk("mixed_read_first", 64'({ar_ready[0], aw_ready[0], w_ready[0]}), 3'b100);
        tick();
        ar_valid[0] = 1'b0;
        ref_read(32'h40, ed, er);
        finish_read(0, ed, er, 0);
        chk("mixed_write_next", 64'({ar_ready[0], aw_ready[0], w_ready[0]}), 3'b011);
        tick();
        aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
        chk("mixed_we", 64'(slave_we), 4'hF);
        chk("mixed_waddr", 64'(slave_addr), 16);
        tick();
        chk("mixed_b_valid", 64'(b_valid[0]), 1);
        b_ready[0] = 1'b1;
        tick();
        b_ready[0] = 1'b0;
        ref_write(32'h40, 32'h5A5A5A5A, 4'hF);
        do_read(0, 32'h40, 32'h5A5A5A5A, 2'b00, 0);

        // Randomised traffic against the reference memory
        for (int t = 0; t < 40; t++) begin
            m = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else a = ($urandom_range(0, 1023) * 4) + $urandom_range(0, 3);
            if ((a / 4) == 32) a = a + 4;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                do_write(m, a, d, s, is_oor(a) ? 4'h0 : s, is_oor(a) ? 2'b10 : 2'b00,
                         int'($urandom_range(0, 2)));
                ref_write(a, d, s);
            end else begin
                ref_read(a, ed, er);
                do_read(m, a, ed, er, int'($urandom_range(0, 2)));
            end
        end

        // Reset while in WR_MEM (master0 granted, so rr points at master1)
        aw_valid[0] = 1'b1; w_valid[0] = 1'b1;
        aw_addr[0 +: AW] = 32'h80;
        w_data[0 +: DW] = 32'h0BADF00D;
        w_strb[0 +: SW] = 4'hF;
        #1;
        chk("rstw_grant", 64'(aw_ready[0]), 1);
        tick();
        aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
        chk("rstw_in_wr_mem", 64'(slave_we), 4'hF);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_wr_mem");
        tick();
        chk("rstw_no_b", 64'(b_valid), 0);
        rst_n = 1'b1;
        both_reads_after_reset(32'h10, 32'h24);

        // Reset while in RD_RESP
        ref_read(32'h30, ed, er);
        ar_valid[0] = 1'b1;
        ar_addr[0 +: AW] = 32'h30;
        #1;
        chk("rstr_grant", 64'(ar_ready[0]), 1);
        tick();
        ar_valid[0] = 1'b0;
        n = 1;
        while (!r_valid[0] && n < 20) begin tick(); n++; end
        chk("rstr_in_rd_resp", 64'(r_valid[0]), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_rd_resp");
        tick();
        rst_n = 1'b1;
        both_reads_after_reset(32'h44, 32'h48);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
